// File: rtl/mux8_pkg.sv
// rtl/mux8_pkg.sv - shared constants and state type for the 8:1 mux scan sequencer
package mux8_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/mux8_scan_ctrl_if.sv
// rtl/mux8_scan_ctrl_if.sv - request, mux and snapshot signals of the scan sequencer
interface mux8_scan_if;
    import mux8_pkg::*;

    logic              start;
    logic [NUM_CH-1:0] ch_mask;
    logic [SEL_W-1:0]  sel;
    logic              mux_y;
    logic [NUM_CH-1:0] snap_data;
    logic              snap_valid;
    logic              snap_ready;
    logic              busy;

    // Sequencer side
    modport slave (
        input  start, ch_mask, mux_y, snap_ready,
        output sel, snap_data, snap_valid, busy
    );

    // Requester / consumer / mux side
    modport master (
        output start, ch_mask, mux_y, snap_ready,
        input  sel, snap_data, snap_valid, busy
    );

endinterface

// File: rtl/mux8_next_ch.sv
// rtl/mux8_next_ch.sv - picks the next enabled channel in ascending order
module mux8_next_ch
    import mux8_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              from_start,
    output logic [SEL_W-1:0]  nxt,
    output logic              found
);

    // Scan from the top down so the lowest qualifying channel wins; when not
    // starting a scan only channels strictly above cur qualify (no wrap).
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur)))) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux8_scan_ctrl.sv
// rtl/mux8_scan_ctrl.sv - steps the 8:1 mux select, settles, samples and emits a snapshot
module mux8_scan_ctrl
    import mux8_pkg::*;
#(
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    mux8_scan_if.slave bus
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC);
    localparam state_t           AFTER_SEL   = (SETTLE_CYC > 0) ? SETTLE : SAMPLE;

    state_t            state_q;
    logic [SEL_W-1:0]  sel_q;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] acc_q;
    logic [NUM_CH-1:0] acc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] snap_data_q;
    logic              snap_valid_q;
    logic              busy_q;

    logic              from_start;
    logic [NUM_CH-1:0] search_mask;
    logic [SEL_W-1:0]  nxt_ch;
    logic              nxt_found;

    // In IDLE the search runs over the incoming mask; during a scan it runs
    // over the latched copy so later ch_mask changes cannot disturb it.
    assign from_start  = (state_q == IDLE);
    assign search_mask = from_start ? bus.ch_mask : mask_q;

    mux8_next_ch u_next_ch (
        .mask       (search_mask),
        .cur        (sel_q),
        .from_start (from_start),
        .nxt        (nxt_ch),
        .found      (nxt_found)
    );

    // Accumulator with the sample currently on mux_y merged into the selected bit
    always_comb begin
        acc_d        = acc_q;
        acc_d[sel_q] = bus.mux_y;
    end

    // Scan sequencer: state, select, settle counter and snapshot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            mask_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            snap_data_q  <= '0;
            snap_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (nxt_found) begin
                            mask_q  <= bus.ch_mask;
                            acc_q   <= '0;
                            sel_q   <= nxt_ch;
                            cnt_q   <= SETTLE_LOAD;
                            state_q <= AFTER_SEL;
                        end else begin
                            // Empty mask: deliver an all-zero snapshot straight away
                            snap_data_q  <= '0;
                            snap_valid_q <= 1'b1;
                            state_q      <= HOLD;
                        end
                    end
                end

                SETTLE: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= SAMPLE;
                    end
                end

                SAMPLE: begin
                    acc_q <= acc_d;
                    if (nxt_found) begin
                        sel_q   <= nxt_ch;
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= AFTER_SEL;
                    end else begin
                        snap_data_q  <= acc_d;
                        snap_valid_q <= 1'b1;
                        state_q      <= HOLD;
                    end
                end

                HOLD: begin
                    if (bus.snap_ready) begin
                        snap_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sel        = sel_q;
    assign bus.snap_data  = snap_data_q;
    assign bus.snap_valid = snap_valid_q;
    assign bus.busy       = busy_q;

endmodule

// File: doc/mux8_scan_ctrl.md
Name: mux8_scan_ctrl

Overview:
Sequencer that sits directly upstream of the 8:1 select mux. It drives the mux select lines, steps through a programmable set of channels, and waits a settle time after each select change. It then samples the mux output and assembles the samples into an 8-bit snapshot, delivered to the consumer over a valid/ready handshake.

Parameters:
SETTLE_CYC, 1, idle cycles between a select change and the sample of mux_y (0 allowed)
CNT_W, 4, width of settle counter; SETTLE_CYC must be at most 2**CNT_W-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to begin a scan; sampled only in IDLE
ch_mask  in  8  channel enable mask, bit i = channel i; latched on accepted start
sel  out  3  channel index to mux; sel[0]->s0, sel[1]->s1, sel[2]->s2
mux_y  in  1  selected mux output
snap_data  out  8  snapshot, bit i = sample of channel i, 0 for disabled channels
snap_valid  out  1  snapshot available
snap_ready  in  1  consumer accepts snapshot
busy  out  1  high in every state except IDLE

Behaviour:
- Clocking and reset: one clock (clk). rst is asynchronous and active-high.
- Reset values: sel=0, snap_data=0, snap_valid=0, busy=0, state=IDLE, accumulator=0, latched mask=0, counter=0.
- States: IDLE, SETTLE, SAMPLE, HOLD.
- IDLE
  - start=1 and ch_mask!=0: latch mask; clear accumulator; set sel = lowest set bit of mask; counter=SETTLE_CYC.
  - Next state is SETTLE if SETTLE_CYC>0, else SAMPLE.
  - start=1 and ch_mask==0: snap_data<=0, snap_valid<=1, go to HOLD.
  - start=0: stay; sel holds its last value.
- SETTLE
  - Counter decrements each cycle.
  - Move to SAMPLE on the cycle the counter reaches 1, so SETTLE occupies exactly SETTLE_CYC cycles.
- SAMPLE (1 cycle)
  - acc[sel] <= mux_y.
  - If a higher set bit exists in the latched mask: sel <= that index, reload counter, go to SETTLE (or SAMPLE again when SETTLE_CYC=0).
  - Otherwise: snap_data <= acc with the current bit merged, snap_valid<=1, go to HOLD.
- HOLD
  - snap_valid and snap_data are held stable.
  - When snap_valid & snap_ready: snap_valid<=0 at that edge, go to IDLE.
  - snap_data retains its value after the handshake.
- Latency: with N enabled channels, snap_valid rises N*(SETTLE_CYC+1)+1 edges after the edge that accepts start (N=0 gives 1 edge).
- Channels are visited in ascending index only; there is no wrap-around within a scan. sel changes only on SAMPLE->next transitions and on start acceptance.
- start while busy: ignored, not queued. ch_mask changes after acceptance have no effect on the current scan.
- snap_ready while snap_valid=0: ignored.
- Reset mid-scan: async reset aborts the scan; no partial snapshot is ever presented.
- busy=1 from the edge accepting start until the handshake edge.

Decomposition:
- Package mux8_pkg holds:
  - NUM_CH=8
  - SEL_W=3
  - state enum (IDLE, SETTLE, SAMPLE, HOLD)
- One combinational sub-module, mux8_next_ch.
  - Inputs: mask[7:0], cur[2:0], from_start.
  - Outputs: nxt[2:0], found.
  - Function: finds the lowest set bit of mask when from_start=1, else the lowest set bit strictly above cur.
  - Used both for start acceptance and for the SAMPLE step.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle -> sel=0, snap_valid=0, busy=0, snap_data=0 immediately, without waiting for a clk edge.
2. Full scan: SETTLE_CYC=1, ch_mask=8'hFF, mux_y = pattern 8'hA5 indexed by sel.
   - sel steps 0..7, each held 2 cycles.
   - snap_valid rises 17 edges after start; snap_data=8'hA5.
3. Sparse scan: ch_mask=8'h81, mux_y=1 always -> sel visits 0 then 7 only; snap_data=8'h81; valid at 5 edges.
4. Empty mask: ch_mask=8'h00 -> snap_valid after 1 edge, snap_data=8'h00, sel unchanged.
5. Backpressure: hold snap_ready=0 for 10 cycles with start pulses and ch_mask toggling.
   - snap_valid and snap_data stay stable; start is ignored.
   - Raise ready: valid drops at that edge and busy=0 next cycle.
6. Reset mid-scan: assert rst after the 3rd sample of an 8'hFF scan -> outputs return to reset values. A fresh start with ch_mask=8'h0F and pattern 8'h0A yields snap_data=8'h0A with no stale bits.
